fixed_point_l1_acc: RTL and testbench
=====================================

FIXED_POINT_L1_ACC -- requirements
Module: fixed_point_l1_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, input sample width in bits.
REQ-002 SHALL have parameter FRAC_BITS, default 3, fractional bits of input and sum; sum keeps the same binary point.
REQ-003 SHALL have parameter ACC_WIDTH, default 16, sum width, constrained ACC_WIDTH > WIDTH.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, width of the block-length field.
REQ-005 SHALL have port CLK  input  1  single clock, rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port START  input  1  begin a block; sampled in IDLE only.
REQ-008 SHALL have port LENGTH  input  LEN_WIDTH  samples per block, latched on accepted START.
REQ-009 SHALL have port VALUE_IN  input  WIDTH  magnitude sample from the upstream absolute-value stage.
REQ-010 SHALL have port VALID_IN  input  1  VALUE_IN qualifier, one sample per cycle, no backpressure.
REQ-011 SHALL have port OVERFLOW_IN  input  1  upstream overflow flag for the current sample.
REQ-012 SHALL have port SUM_OUT  output  ACC_WIDTH  signed fixed-point block sum.
REQ-013 SHALL have port SUM_VALID  output  1  SUM_OUT valid, held until handshake.
REQ-014 SHALL have port SUM_READY  input  1  downstream accept; transfer when SUM_VALID and SUM_READY.
REQ-015 SHALL have port OVERFLOW_OUT  output  1  sticky block overflow, valid with SUM_VALID.
REQ-016 SHALL have port BUSY  output  1  high in ACCUM and HOLD.

Function
REQ-017 SHALL implement the states IDLE, ACCUM and HOLD.
- IDLE: START with LENGTH>0 -> ACCUM; START with LENGTH=0 -> HOLD, sum 0, no overflow.
- ACCUM: accumulate each VALID_IN; the LENGTH-th accepted sample -> HOLD.
- HOLD: SUM_VALID=1; handshake -> IDLE.
REQ-018 SHALL clear the accumulator, sample counter and sticky overflow on the cycle START is accepted.
REQ-019 SHALL zero-extend VALUE_IN as an unsigned WIDTH-bit magnitude, so 0x80 with WIDTH=8 counts as +128 LSBs.
REQ-020 SHALL OR OVERFLOW_IN into the sticky overflow for every accepted sample.
REQ-021 SHALL assert SUM_VALID in the cycle after the final accepted sample (latency 1), with SUM_OUT including that sample.
REQ-022 SHALL hold SUM_OUT, SUM_VALID and OVERFLOW_OUT stable in HOLD until the handshake.
REQ-023 SHALL ignore START in ACCUM and HOLD, including on the handshake cycle; a new block needs one IDLE cycle.
REQ-024 SHALL drop VALID_IN samples in IDLE and HOLD without any state change.
REQ-025 SHALL set the sticky overflow when the sum would exceed 2^(ACC_WIDTH-1)-1 LSBs.

Reset
REQ-026 SHALL, on RST asserted, enter IDLE immediately regardless of CLK, including mid-block or mid-HOLD, and discard any partial sum.
REQ-027 SHALL, while RST is asserted, drive SUM_OUT=0, SUM_VALID=0, OVERFLOW_OUT=0, BUSY=0, and clear the counter.
REQ-028 SHALL treat the first rising CLK after RST deasserts as an ordinary IDLE cycle.

Configuration
REQ-029 SHALL provide the macro FIXED_POINT_L1_ACC_SAT_EN.
- Defined: on overflow the sum clamps at 2^(ACC_WIDTH-1)-1 and stays clamped for the rest of the block.
- Undefined: the sum wraps modulo 2^ACC_WIDTH.
- OVERFLOW_OUT behaves identically in both cases.

Structure
REQ-030 SHALL take state encodings (IDLE=0, ACCUM=1, HOLD=2) and the max-positive constant function from the shared fixed-point package.
REQ-031 SHALL place the saturating/wrapping add in one combinational sub-module, fixed_point_sat_add, with ports a, b, sum and ovf.

Verification
REQ-032 SHALL cover: WIDTH=8, LENGTH=4, samples 0x08,0x10,0x18,0x20 -> SUM_OUT=0x0050 one cycle after the 4th sample, OVERFLOW_OUT=0.
REQ-033 SHALL cover: sample 0x80 with OVERFLOW_IN=1, LENGTH=1 -> SUM_OUT=0x0080, OVERFLOW_OUT=1.
REQ-034 SHALL cover: ACC_WIDTH=9, LENGTH=3, samples 0x7F x3 -> with SAT_EN SUM_OUT=0x0FF and OVERFLOW_OUT=1; without SAT_EN SUM_OUT=0x17D and OVERFLOW_OUT=1.
REQ-035 SHALL cover: SUM_READY low 5 cycles in HOLD, with START and VALID_IN pulsed meanwhile -> outputs stable and no new block; block starts only after handshake plus one IDLE cycle.
REQ-036 SHALL cover: RST pulsed (not clock-aligned) after 2 of 4 samples -> outputs 0 immediately; a following LENGTH=2 block with samples 0x01,0x02 sums to 0x0003.
REQ-037 SHALL cover: LENGTH=0 START -> SUM_VALID next cycle with SUM_OUT=0.

Source files
------------

// File: rtl/fixed_point_l1_acc_pkg.sv
// Shared fixed-point definitions: FSM state encodings and the max-positive constant helper.
package fixed_point_l1_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Largest positive value of a signed two's-complement word of the given width.
    function automatic longint unsigned max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/fixed_point_sat_add.sv
// Accumulator adder for non-negative increments; FIXED_POINT_L1_ACC_SAT_EN selects
// clamp-to-max-positive instead of modulo wrap.
module fixed_point_sat_add
    import fixed_point_l1_acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

`ifdef FIXED_POINT_L1_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] MAX_POS = ACC_WIDTH'(max_pos(ACC_WIDTH));
`endif

    logic [ACC_WIDTH-1:0] raw;

    always_comb begin
        raw = a + b;
        // Two non-negative operands producing a negative result crossed max-positive.
        ovf = ~a[ACC_WIDTH-1] & ~b[ACC_WIDTH-1] & raw[ACC_WIDTH-1];
`ifdef FIXED_POINT_L1_ACC_SAT_EN
        sum = ovf ? MAX_POS : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/fixed_point_l1_acc.sv
// Block L1 accumulator: sums LENGTH magnitude samples and holds the result until accepted.
// Optional FIXED_POINT_L1_ACC_SAT_EN makes the sum saturate instead of wrapping.
module fixed_point_l1_acc
    import fixed_point_l1_acc_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAC_BITS = 3,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] LENGTH,
    input  logic [WIDTH-1:0]     VALUE_IN,
    input  logic                 VALID_IN,
    input  logic                 OVERFLOW_IN,
    output logic [ACC_WIDTH-1:0] SUM_OUT,
    output logic                 SUM_VALID,
    input  logic                 SUM_READY,
    output logic                 OVERFLOW_OUT,
    output logic                 BUSY
);

    if (ACC_WIDTH <= WIDTH || FRAC_BITS > WIDTH) begin : g_bad_params
        $error("fixed_point_l1_acc: need ACC_WIDTH > WIDTH and FRAC_BITS <= WIDTH");
    end

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   sample_ext;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_ovf;

    // Samples are unsigned magnitudes, so 0x80 contributes +128 LSBs.
    assign sample_ext = {{(ACC_WIDTH - WIDTH){1'b0}}, VALUE_IN};

    fixed_point_sat_add #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_add (
        .a  (acc_q),
        .b  (sample_ext),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    len_d   = LENGTH;
                    state_d = (LENGTH == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (VALID_IN) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | OVERFLOW_IN | add_ovf;
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (cnt_d == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (SUM_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SUM_OUT      = acc_q;
    assign SUM_VALID    = (state_q == HOLD);
    assign OVERFLOW_OUT = ovf_q;
    assign BUSY         = (state_q == ACCUM) || (state_q == HOLD);

endmodule

// File: tb/tb_fixed_point_l1_acc.sv
// Scoreboard bench for fixed_point_l1_acc: a default instance and a narrow ACC_WIDTH=9 instance
// share stimulus; expected sums come from an unbounded-integer model.
module tb_fixed_point_l1_acc;

`ifdef FIXED_POINT_L1_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] s16;
        logic        o16;
        logic [8:0]  s9;
        logic        o9;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic [7:0]  value_in;
    logic        valid_in;
    logic        overflow_in;
    logic        sum_ready;
    logic [15:0] sum16;
    logic        valid16, ovf16, busy16;
    logic [8:0]  sum9;
    logic        valid9, ovf9, busy9;

    int   tests_run = 0;
    int   failures  = 0;
    exp_t sb[$];
    logic [7:0] stim_v[$];
    bit         stim_o[$];

    always #5 clk = ~clk;

    fixed_point_l1_acc dut16 (
        .CLK(clk), .RST(rst), .START(start), .LENGTH(length), .VALUE_IN(value_in),
        .VALID_IN(valid_in), .OVERFLOW_IN(overflow_in), .SUM_OUT(sum16), .SUM_VALID(valid16),
        .SUM_READY(sum_ready), .OVERFLOW_OUT(ovf16), .BUSY(busy16)
    );

    fixed_point_l1_acc #(.ACC_WIDTH(9)) dut9 (
        .CLK(clk), .RST(rst), .START(start), .LENGTH(length), .VALUE_IN(value_in),
        .VALID_IN(valid_in), .OVERFLOW_IN(overflow_in), .SUM_OUT(sum9), .SUM_VALID(valid9),
        .SUM_READY(sum_ready), .OVERFLOW_OUT(ovf9), .BUSY(busy9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int w, output logic [15:0] s, output logic o);
        longint run  = 0;
        longint maxp = (longint'(1) << (w - 1)) - 1;
        o = 1'b0;
        foreach (stim_v[i]) begin
            run += longint'(stim_v[i]);
            if (stim_o[i]) o = 1'b1;
            if (run > maxp) begin
                o = 1'b1;
                if (SAT) run = maxp;
            end
        end
        s = 16'(run % (longint'(1) << w));
    endfunction

    task automatic push_expected();
        exp_t e;
        logic [15:0] s;
        logic o;
        model(16, s, o);
        e.s16 = s;
        e.o16 = o;
        model(9, s, o);
        e.s9 = s[8:0];
        e.o9 = o;
        sb.push_back(e);
    endtask

    task automatic start_block(input logic [7:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v, input logic o);
        valid_in    = 1'b1;
        value_in    = v;
        overflow_in = o;
        tick();
        valid_in    = 1'b0;
        overflow_in = 1'b0;
    endtask

    task automatic run_block(input logic [7:0] len);
        push_expected();
        start_block(len);
        foreach (stim_v[i]) feed(stim_v[i], stim_o[i]);
    endtask

    task automatic check_output(input string name);
        int   waited = 0;
        exp_t e;
        while (valid16 !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tests_run++;
        if (valid16 !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid: SUM_VALID=%b required 1 within 20 cycles", name, valid16);
        end
        tests_run++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: queue empty, required one entry", name);
            return;
        end
        e = sb.pop_front();
        tests_run += 4;
        if (sum16 !== e.s16) begin
            failures++;
            $display("FAIL %s_sum16: got 0x%04h required 0x%04h", name, sum16, e.s16);
        end
        if (ovf16 !== e.o16) begin
            failures++;
            $display("FAIL %s_ovf16: got %b required %b", name, ovf16, e.o16);
        end
        if (sum9 !== e.s9) begin
            failures++;
            $display("FAIL %s_sum9: got 0x%03h required 0x%03h", name, sum9, e.s9);
        end
        if (ovf9 !== e.o9) begin
            failures++;
            $display("FAIL %s_ovf9: got %b required %b", name, ovf9, e.o9);
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        tests_run++;
        if (valid16 !== 1'b0 || valid9 !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: SUM_VALID=%b/%b required 0/0", name, valid16, valid9);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({sum16, valid16, ovf16, busy16} !== 19'd0 || {sum9, valid9, ovf9, busy9} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b required 0/0/0/0",
                     sum16, valid16, ovf16, busy16);
        end
        #11 rst = 1'b0;
        tick();
        tests_run++;
        if (busy16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: BUSY=%b required 0", busy16);
        end
    endtask

    task automatic test_basic_sum();
        // Sample while idle must be dropped.
        valid_in = 1'b1;
        value_in = 8'h55;
        tick();
        valid_in = 1'b0;
        tests_run++;
        if (busy16 !== 1'b0 || valid16 !== 1'b0) begin
            failures++;
            $display("FAIL idle_drop: BUSY=%b SUM_VALID=%b required 0/0", busy16, valid16);
        end
        stim_v = '{8'h08, 8'h10, 8'h18, 8'h20};
        stim_o = '{0, 0, 0, 0};
        push_expected();
        start_block(8'd4);
        tests_run++;
        if (busy16 !== 1'b1) begin
            failures++;
            $display("FAIL accum_busy: BUSY=%b required 1", busy16);
        end
        feed(8'h08, 1'b0);
        feed(8'h10, 1'b0);
        tick();  // gap cycle with VALID_IN low
        feed(8'h18, 1'b0);
        tests_run++;
        if (valid16 !== 1'b0) begin
            failures++;
            $display("FAIL early_valid: SUM_VALID=%b required 0 before last sample", valid16);
        end
        feed(8'h20, 1'b0);
        tests_run++;
        if (valid16 !== 1'b1) begin
            failures++;
            $display("FAIL latency: SUM_VALID=%b required 1 one cycle after last sample", valid16);
        end
        check_output("basic");
    endtask

    task automatic test_ovf_in();
        stim_v = '{8'h80};
        stim_o = '{1};
        run_block(8'd1);
        check_output("ovf_in");
    endtask

    task automatic test_acc_overflow();
        stim_v = '{8'h7F, 8'h7F, 8'h7F};
        stim_o = '{0, 0, 0};
        run_block(8'd3);
        check_output("acc_ovf");
    endtask

    task automatic test_hold();
        logic [15:0] held;
        stim_v = '{8'h05, 8'h06};
        stim_o = '{0, 0};
        run_block(8'd2);
        held = sb[0].s16;
        for (int i = 0; i < 5; i++) begin
            start    = (i == 1);
            length   = 8'd1;
            valid_in = (i == 2 || i == 3);
            value_in = 8'h33;
            tick();
            start    = 1'b0;
            valid_in = 1'b0;
            tests_run++;
            if (valid16 !== 1'b1 || sum16 !== held || ovf16 !== 1'b0 || busy16 !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable_%0d: got v=%b s=0x%04h o=%b b=%b required 1/0x%04h/0/1",
                         i, valid16, sum16, ovf16, busy16, held);
            end
        end
        // START held through the handshake must not launch a block on that edge.
        start  = 1'b1;
        length = 8'd1;
        check_output("hold");
        tests_run++;
        if (busy16 !== 1'b0) begin
            failures++;
            $display("FAIL hold_start_ignored: BUSY=%b required 0", busy16);
        end
        stim_v = '{8'h09};
        stim_o = '{0};
        push_expected();
        tick();
        start = 1'b0;
        tests_run++;
        if (busy16 !== 1'b1) begin
            failures++;
            $display("FAIL after_idle_start: BUSY=%b required 1", busy16);
        end
        feed(8'h09, 1'b0);
        check_output("after_hold");
    endtask

    task automatic test_async_reset();
        start_block(8'd4);
        feed(8'h01, 1'b0);
        feed(8'h02, 1'b0);
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if ({sum16, valid16, ovf16, busy16} !== 19'd0 || busy9 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got s=0x%04h v=%b o=%b b=%b required 0/0/0/0",
                     sum16, valid16, ovf16, busy16);
        end
        #3 rst = 1'b0;
        tick();
        stim_v = '{8'h01, 8'h02};
        stim_o = '{0, 0};
        run_block(8'd2);
        check_output("post_reset");
    endtask

    task automatic test_zero_length();
        stim_v = {};
        stim_o = {};
        run_block(8'd0);
        tests_run++;
        if (valid16 !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_latency: SUM_VALID=%b required 1", valid16);
        end
        check_output("zero_len");
    endtask

    initial begin
        start       = 1'b0;
        length      = '0;
        value_in    = '0;
        valid_in    = 1'b0;
        overflow_in = 1'b0;
        sum_ready   = 1'b0;
        test_reset();
        test_basic_sum();
        test_ovf_in();
        test_acc_overflow();
        test_hold();
        test_async_reset();
        test_zero_length();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
